rep_window_checker: RTL

REP_WINDOW_CHECKER -- requirements
Module: rep_window_checker

---
 rtl/rep_window_checker.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rep_window_checker.sv
// Sequence checker for trig ##1 expr[*MIN_REP:MAX_REP] ##1 term, single non-overlapping attempt.
// Define REP_CHECK_STATS_EN to add saturating fail_total / dropped_trig statistics outputs.
module rep_window_checker #(
  parameter int MIN_REP = 2,
  parameter int MAX_REP = 4,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             trig,
  input  logic             expr,
  input  logic             term,
  output logic             active,
  output logic [CNT_W-1:0] rep_count,
  output logic             pass,
  output logic             fail
`ifdef REP_CHECK_STATS_EN
  ,
  output logic [15:0]      fail_total,
  output logic [15:0]      dropped_trig
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_REP);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_REP);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rep_count_q, rep_count_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] cnt_inc;

  // MAX_REP <= 2**CNT_W-2 guarantees MAX_REP+1 is representable, so no wrap.
  assign cnt_inc = rep_count_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    rep_count_d = rep_count_q;
    pass_d      = 1'b0;
    fail_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && trig) begin
          state_d     = COUNT;
          rep_count_d = '0;
        end
      end
      COUNT: begin
        if (!en) begin
          state_d     = IDLE;
          rep_count_d = '0;
        end else if (expr) begin
          rep_count_d = cnt_inc;
          if (cnt_inc > MAX_C) begin
            fail_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
          if ((rep_count_q >= MIN_C) && (rep_count_q <= MAX_C) && term) begin
            pass_d = 1'b1;
          end else begin
            fail_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rep_count_q <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rep_count_q <= rep_count_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  assign active    = (state_q == COUNT);
  assign rep_count = rep_count_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

`ifdef REP_CHECK_STATS_EN
  logic [15:0] fail_total_q, fail_total_d;
  logic [15:0] dropped_trig_q, dropped_trig_d;

  // fail_total moves on the same edge that registers the fail pulse.
  always_comb begin
    fail_total_d   = fail_total_q;
    dropped_trig_d = dropped_trig_q;
    if (fail_d && (fail_total_q != 16'hFFFF)) begin
      fail_total_d = fail_total_q + 16'd1;
    end
    if ((state_q == COUNT) && trig && (dropped_trig_q != 16'hFFFF)) begin
      dropped_trig_d = dropped_trig_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_total_q   <= '0;
      dropped_trig_q <= '0;
    end else begin
      fail_total_q   <= fail_total_d;
      dropped_trig_q <= dropped_trig_d;
    end
  end

  assign fail_total   = fail_total_q;
  assign dropped_trig = dropped_trig_q;
`endif

endmodule
